// File: rtl/mul_stream_engine.sv
// Byte-stream multiply / MAC engine: gathers A and B LSB first, multiplies
// iteratively by shift-add, then streams the result back one byte at a time.
module mul_stream_engine #(
  parameter int W          = 8,
  parameter int TX_GAP     = 100,
  parameter int RX_TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frames_received,
  output logic       rx_timeout_err,
  output logic       done
);

  localparam int NB    = W / 8;
  localparam int NBT   = 2 * NB;
  localparam int ACC_W = 2 * W + 8;
  localparam int ACC_B = ACC_W / 8;
  localparam int CW    = $clog2(NBT) + 1;
  localparam int TW    = $clog2(RX_TIMEOUT + 1);
  localparam int MW    = $clog2(W + 1);
  localparam int BW    = $clog2(ACC_B + 1);
  localparam int GW    = $clog2(TX_GAP + 2);

  localparam logic [CW-1:0] C_LAST = CW'(NBT - 1);
  localparam logic [TW-1:0] T_LAST = TW'(RX_TIMEOUT - 1);
  localparam logic [MW-1:0] M_LAST = MW'(W - 1);
  localparam logic [BW-1:0] P_LAST = BW'(NBT - 1);
  localparam logic [BW-1:0] A_LAST = BW'(ACC_B - 1);
  localparam logic [GW-1:0] G_LAST =
    GW'((TX_GAP > 0) ? TX_GAP - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, RX, MUL, FIX, TX_BYTE, TX_WAIT, DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [TW-1:0]    tcnt;
  logic [MW-1:0]    mcnt;
  logic [BW-1:0]    bidx;
  logic [GW-1:0]    gcnt;
  logic [2*W-1:0]   opnd;
  logic [1:0]       mode_q;
  logic [2*W-1:0]   prod;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] res;

  logic [W-1:0]     a_op, b_op;
  logic [W-1:0]     a_mag, b_mag, b_sh;
  logic             sgn, neg;
  logic [2*W-1:0]   pp, prod_f;
  logic [ACC_W-1:0] p_ext, sum;
  logic             rx_hit, last_rx, tmo;
  logic             tx_last;
  logic [BW-1:0]    nb_last;

  // Signed mode multiplies magnitudes; sign is restored in FIX.
  always_comb begin
    a_op   = opnd[W-1:0];
    b_op   = opnd[2*W-1:W];
    sgn    = (mode_q == 2'b01);
    a_mag  = (sgn && a_op[W-1]) ? -a_op : a_op;
    b_mag  = (sgn && b_op[W-1]) ? -b_op : b_op;
    neg    = sgn && (a_op[W-1] ^ b_op[W-1]);
    b_sh   = b_mag >> mcnt;
    pp     = b_sh[0] ? ({{W{1'b0}}, a_mag} << mcnt) : '0;
    prod_f = neg ? -prod : prod;
    p_ext  = {8'h00, prod};
    sum    = acc + p_ext;
  end

  always_comb begin
    rx_hit  = (state == RX) && enable && rx_valid;
    last_rx = rx_hit && (cnt == C_LAST);
    tmo     = (state == RX) && enable && !rx_valid &&
              (cnt != '0) && (tcnt == T_LAST);
    nb_last = mode_q[1] ? A_LAST : P_LAST;
    tx_last = (bidx == nb_last);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n         = state;
    tx_valid        = 1'b0;
    tx_data         = 8'h00;
    busy            = (state != IDLE);
    frames_received = last_rx;
    rx_timeout_err  = tmo;
    done            = 1'b0;
    case (state)
      IDLE:    if (enable) state_n = RX;
      RX: begin
        if (!enable)     state_n = IDLE;
        else if (last_rx) state_n = MUL;
      end
      MUL:     if (mcnt == M_LAST) state_n = FIX;
      FIX:     state_n = TX_BYTE;
      TX_BYTE: begin
        tx_valid = 1'b1;
        tx_data  = res[7:0];
        if (tx_ready) begin
          if (tx_last)         state_n = DONE;
          else if (TX_GAP > 0) state_n = TX_WAIT;
        end
      end
      TX_WAIT: if (gcnt == G_LAST) state_n = TX_BYTE;
      DONE: begin
        done    = 1'b1;
        state_n = enable ? RX : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      tcnt   <= '0;
      mcnt   <= '0;
      bidx   <= '0;
      gcnt   <= '0;
      opnd   <= '0;
      mode_q <= 2'b00;
      prod   <= '0;
      acc    <= '0;
      res    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            cnt  <= '0;
            tcnt <= '0;
          end
        end
        RX: begin
          if (!enable) begin
            cnt  <= '0;
            tcnt <= '0;
          end else if (rx_valid) begin
            for (int i = 0; i < NBT; i++)
              if (cnt == CW'(i)) opnd[8*i +: 8] <= rx_data;
            tcnt <= '0;
            if (cnt == C_LAST) begin
              cnt    <= '0;
              mode_q <= mode;
              mcnt   <= '0;
              prod   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (cnt != '0) begin
            if (tmo) begin
              cnt  <= '0;
              tcnt <= '0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        MUL: begin
          prod <= prod + pp;
          mcnt <= mcnt + 1'b1;
        end
        FIX: begin
          bidx <= '0;
          case (mode_q)
            2'b10: begin
              acc <= sum;
              res <= sum;
            end
            2'b11: begin
              acc <= p_ext;
              res <= p_ext;
            end
            default: res <= {8'h00, prod_f};
          endcase
        end
        TX_BYTE: begin
          gcnt <= '0;
          if (tx_ready) begin
            res  <= res >> 8;
            bidx <= bidx + 1'b1;
          end
        end
        TX_WAIT: gcnt <= gcnt + 1'b1;
        DONE: begin
          if (enable) begin
            cnt  <= '0;
            tcnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_stream_engine.sv
// Scoreboard bench: W=8 engine with a byte gap, W=16 engine back-to-back
// with backpressure and a mid-transmit reset.
module tb_mul_stream_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a, rxv_a, txv_a, rdy_a;
  logic       busy_a, fr_a, to_a, done_a;
  logic [1:0] mode_a;
  logic [7:0] rxd_a, txd_a;

  logic       rst_b, en_b, rxv_b, txv_b, rdy_b;
  logic       busy_b, fr_b, to_b, done_b;
  logic [1:0] mode_b;
  logic [7:0] rxd_b, txd_b;

  mul_stream_engine #(.W(8), .TX_GAP(4), .RX_TIMEOUT(50)) dut_a (
    .clk(clk), .reset(rst_a), .enable(en_a), .mode(mode_a),
    .rx_data(rxd_a), .rx_valid(rxv_a),
    .tx_data(txd_a), .tx_valid(txv_a), .tx_ready(rdy_a),
    .busy(busy_a), .frames_received(fr_a),
    .rx_timeout_err(to_a), .done(done_a)
  );

  mul_stream_engine #(.W(16), .TX_GAP(0), .RX_TIMEOUT(1000)) dut_b (
    .clk(clk), .reset(rst_b), .enable(en_b), .mode(mode_b),
    .rx_data(rxd_b), .rx_valid(rxv_b),
    .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(rdy_b),
    .busy(busy_b), .frames_received(fr_b),
    .rx_timeout_err(to_b), .done(done_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  int idle_a = 0, lat_a = 0;
  int fr_cnt_a = 0, done_cnt_a = 0, to_cnt_a = 0;
  bit lat_on_a = 0, in_fr_a = 0, pv_a = 0;

  always @(negedge clk) begin
    if (!rst_a) begin
      lat_on_a = 0; in_fr_a = 0; pv_a = 0; idle_a = 0;
    end else begin
      if (fr_a) begin
        fr_cnt_a++; lat_a = 0; lat_on_a = 1;
      end else if (lat_on_a) lat_a++;
      if (lat_on_a && txv_a) begin
        chk("latency_a", lat_a, 10);
        lat_on_a = 0;
      end
      if (txv_a && !pv_a && in_fr_a) chk("gap_a", idle_a, 4);
      if (!txv_a) idle_a++;
      if (txv_a && rdy_a) begin
        if (exp_a.size() == 0) chk("extra_byte_a", {24'h0, txd_a}, 32'h100);
        else chk("byte_a", txd_a, exp_a.pop_front());
        idle_a = 0; in_fr_a = 1;
      end
      if (done_a) begin done_cnt_a++; in_fr_a = 0; end
      if (to_a) to_cnt_a++;
      pv_a = txv_a;
    end
  end

  int lat_b = 0, bcnt_b = 0, pops_b = 0, done_cnt_b = 0;
  bit lat_on_b = 0, need_v = 0, hold_v = 0;
  logic [7:0] hold_d;

  always @(negedge clk) begin
    if (!rst_b) begin
      lat_on_b = 0; need_v = 0; hold_v = 0; bcnt_b = 0;
    end else begin
      if (fr_b) begin
        lat_b = 0; lat_on_b = 1;
      end else if (lat_on_b) lat_b++;
      if (lat_on_b && txv_b) begin
        chk("latency_b", lat_b, 18);
        lat_on_b = 0;
      end
      if (need_v) begin
        chk("b2b_valid_b", txv_b, 1);
        need_v = 0;
      end
      if (hold_v) begin
        chk("hold_valid_b", txv_b, 1);
        chk("hold_data_b", txd_b, hold_d);
      end
      hold_v = txv_b && !rdy_b;
      hold_d = txd_b;
      if (txv_b && rdy_b) begin
        if (exp_b.size() == 0) chk("extra_byte_b", {24'h0, txd_b}, 32'h100);
        else chk("byte_b", txd_b, exp_b.pop_front());
        pops_b++; bcnt_b++;
        if (bcnt_b < 4) need_v = 1;
        else bcnt_b = 0;
      end
      if (done_b) done_cnt_b++;
    end
  end

  task automatic rx_a(input logic [7:0] d);
    @(posedge clk); #1 rxd_a = d; rxv_a = 1'b1;
    @(posedge clk); #1 rxv_a = 1'b0;
  endtask

  task automatic rx_b(input logic [7:0] d);
    @(posedge clk); #1 rxd_b = d; rxv_b = 1'b1;
    @(posedge clk); #1 rxv_b = 1'b0;
  endtask

  task automatic run_a(input logic [1:0] m, input logic [7:0] x,
                       input logic [7:0] y, input int nd);
    int k;
    mode_a = m;
    rx_a(x);
    rx_a(y);
    k = 0;
    while (done_cnt_a < nd && k < 2000) begin
      @(posedge clk); k++;
    end
    chk("done_a", done_cnt_a, nd);
    chk("drain_a", exp_a.size(), 0);
  endtask

  task automatic send_b(input logic [31:0] v);
    for (int j = 0; j < 4; j++) rx_b(v[8*j +: 8]);
  endtask

  task automatic wait_done_b(input int nd);
    int k;
    k = 0;
    while (done_cnt_b < nd && k < 2000) begin
      @(posedge clk); k++;
    end
    chk("done_b", done_cnt_b, nd);
    chk("drain_b", exp_b.size(), 0);
  endtask

  task automatic push_b(input logic [31:0] v);
    for (int j = 0; j < 4; j++) exp_b.push_back(v[8*j +: 8]);
  endtask

  int i;
  int k;

  initial begin
    rst_a = 0; en_a = 0; rxv_a = 0; rxd_a = 0; mode_a = 0; rdy_a = 1;
    rst_b = 0; en_b = 0; rxv_b = 0; rxd_b = 0; mode_b = 0; rdy_b = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a", {txv_a, txd_a, busy_a, fr_a, to_a, done_a}, 0);
    chk("reset_b", {txv_b, txd_b, busy_b, fr_b, to_b, done_b}, 0);
    rst_a = 1; rst_b = 1; en_a = 1; en_b = 1;
    repeat (2) @(posedge clk);
    #1 chk("busy_a", busy_a, 1);

    exp_a.push_back(8'hC3); exp_a.push_back(8'h00);
    run_a(2'b00, 8'h0F, 8'h0D, 1);
    chk("frames_a", fr_cnt_a, 1);

    exp_a.push_back(8'h00); exp_a.push_back(8'h40);
    run_a(2'b01, 8'h80, 8'h80, 2);
    exp_a.push_back(8'hFE); exp_a.push_back(8'hFF);
    run_a(2'b01, 8'hFF, 8'h02, 3);

    exp_a.push_back(8'h01); exp_a.push_back(8'hFE);
    exp_a.push_back(8'h00);
    run_a(2'b11, 8'hFF, 8'hFF, 4);
    exp_a.push_back(8'h02); exp_a.push_back(8'hFC);
    exp_a.push_back(8'h01);
    run_a(2'b10, 8'hFF, 8'hFF, 5);

    rx_a(8'h77);
    for (i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (to_a) break;
    end
    chk("timeout_at_a", i, 50);
    exp_a.push_back(8'h0F); exp_a.push_back(8'h00);
    run_a(2'b00, 8'h03, 8'h05, 6);
    chk("timeouts_a", to_cnt_a, 1);

    rx_a(8'h11);
    en_a = 0;
    repeat (2) @(posedge clk);
    #1 chk("idle_on_disable_a", busy_a, 0);
    en_a = 1;
    exp_a.push_back(8'h06); exp_a.push_back(8'h00);
    run_a(2'b00, 8'h02, 8'h03, 7);
    chk("frames_total_a", fr_cnt_a, 7);

    rdy_b = 0;
    push_b(32'h0626_0060);
    send_b(32'h5678_1234);
    k = 0;
    while (!txv_b && k < 100) begin
      @(posedge clk); k++;
    end
    chk("first_valid_b", txv_b, 1);
    repeat (50) @(posedge clk);
    #1 rdy_b = 1;
    wait_done_b(1);
    chk("pops_b", pops_b, 4);

    push_b(32'h0626_0060);
    send_b(32'h5678_1234);
    k = 0;
    while (pops_b < 6 && k < 2000) begin
      @(posedge clk); k++;
    end
    chk("mid_pops_b", pops_b, 6);
    #2 rst_b = 0;
    #1;
    chk("midreset_b", {txv_b, txd_b, busy_b, fr_b, to_b, done_b}, 0);
    exp_b.delete();
    repeat (3) @(posedge clk);
    #1 rst_b = 1;
    repeat (20) @(posedge clk);
    #1 chk("no_tx_after_reset_b", pops_b, 6);
    push_b(32'h0626_0060);
    send_b(32'h5678_1234);
    wait_done_b(2);
    chk("pops_final_b", pops_b, 10);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_stream_engine.md
Name: mul_stream_engine

Overview:
Parametrised, protocol-agnostic multiply/MAC engine behind the UART/SPI byte front-ends. It assembles two W-bit operands from a byte stream, LSB byte first, with A before B. It computes an unsigned product, a signed product or a multiply-accumulate using an iterative shift-add datapath, then returns the result bytes over a valid/ready byte interface with a programmable gap between bytes. It adds width scaling, signed and MAC modes, an RX inactivity timeout and TX backpressure.

Parameters:
W, 8, operand width in bits; must be a multiple of 8 and ≥8; NB = W/8 bytes per operand.
TX_GAP, 100, idle clk cycles between transmitted result bytes; 0 means back-to-back.
RX_TIMEOUT, 100000, maximum clk cycles between bytes of a partial operand frame before it is discarded.
(localparam ACC_W = 2W+8; counters sized with $clog2.)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
enable  in  1  run engine; low returns to IDLE from IDLE/RX
mode  in  2  00 unsigned mul, 01 signed mul, 10 MAC accumulate, 11 MAC load (acc = product)
rx_data  in  8  received byte
rx_valid  in  1  1-cycle strobe, rx_data valid
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid
tx_ready  in  1  front-end accepts byte
busy  out  1  high in any state except IDLE
frames_received  out  1  1-cycle pulse when last operand byte stored
rx_timeout_err  out  1  1-cycle pulse when a partial frame is discarded
done  out  1  1-cycle pulse after last result byte accepted

Behaviour:
- Reset (async, active-low): state=IDLE; every output 0; operand regs, accumulator, all counters 0.
- Transfer rule: a TX byte transfers on a clk edge with tx_valid&tx_ready.
- tx_valid/tx_data are stable while tx_valid=1 and tx_ready=0.
- States: IDLE, RX, MUL, FIX, TX_BYTE, TX_WAIT, DONE.
- IDLE: enable=1 → RX; clear byte counter and timeout counter.
- RX: each rx_valid stores rx_data into byte slot cnt (slots 0..NB-1 = A, NB..2NB-1 = B), cnt++, timeout counter cleared.
- RX, last byte: on slot 2NB-1 → frames_received=1 for one cycle; mode latched; → MUL.
- RX, timeout: counter runs only while cnt>0. Reaching RX_TIMEOUT → cnt=0, rx_timeout_err pulse, stay RX, partial bytes dropped.
- RX, enable low: → IDLE, partial frame dropped.
- RX, timeout and rx_valid in the same cycle: the byte wins and the counter clears.
- rx_valid outside RX: ignored.
- MUL: W cycles, one multiplier bit per cycle, LSB first, 2W-bit product register.
- MUL, signed mode: operates on operand magnitudes.
- FIX (1 cycle):
  - mode 01: negate the product if the operand signs differ.
  - mode 10: acc = acc + zero-extended product, modulo 2^ACC_W.
  - mode 11: acc = zero-extended product.
- Latency: first tx_valid is asserted W+2 cycles after the frames_received cycle.
- TX byte count:
  - modes 00/01: 2NB bytes of the product, LSB first.
  - modes 10/11: ACC_W/8 bytes of acc, LSB first.
- TX_BYTE: tx_valid=1 with byte idx until transfer. Then, if last → DONE; else TX_GAP>0 → TX_WAIT; TX_GAP=0 → next byte next cycle with tx_valid held high.
- TX_WAIT: tx_valid=0 for exactly TX_GAP cycles → TX_BYTE.
- enable is ignored in MUL/FIX/TX_BYTE/TX_WAIT; an in-flight result always completes.
- DONE: done pulse for one cycle; enable=1 → RX (next transaction), else → IDLE.
- Accumulator: persists across transactions; cleared only by reset or mode 11.
- Reset mid-operation (any state): immediate return to reset values; no partial byte is transmitted afterwards.
- Width rules: unsigned product exact in 2W bits. Signed product exact two's complement in 2W bits, including (−2^(W−1))² = 2^(2W−2).

Test Plan:
1. W=8, mode 00, rx 0x0F,0x0D → frames_received pulse; tx C3,00; done; gap between bytes exactly TX_GAP cycles with tx_valid=0.
2. W=8, mode 01:
   - A=0x80, B=0x80 → tx 00,40 (+16384).
   - A=0xFF, B=0x02 → tx FE,FF (−2).
3. W=8, MAC:
   - mode 11, A=B=0xFF → tx 01,FE,00.
   - then mode 10, A=B=0xFF → tx 02,FC,01 (0x1FC02).
4. Backpressure: tx_ready low 50 cycles during the first byte → tx_valid=1 and tx_data constant throughout; byte sent once when tx_ready rises; TX_GAP=0 gives back-to-back transfers.
5. Timeout (RX_TIMEOUT=50): one byte, then silence → rx_timeout_err pulse exactly 50 cycles after that byte. Then rx 0x03,0x05 → tx 0F,00, with the stale byte unused.
6. W=16, mode 00, rx 34,12,78,56 → tx 60,00,26,06. Assert reset mid-TX → all outputs 0 immediately; no further tx_valid; next run correct.
